// File: rtl/ifetch_line_queue_if.sv
// Bundles the instruction-fetch line queue's redirect, I-cache and decode signals.
// The master modport is the line queue; the slave modport is its environment.
interface ifetch_line_queue_if #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;

    logic              ic_req_valid;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_req_ready;
    logic              ic_rsp_valid;
    logic [LINE_W-1:0] ic_rsp_data;

    logic              de_lower_valid;
    logic              de_upper_valid;
    logic [LINE_W-1:0] de_lower_data;
    logic [LINE_W-1:0] de_upper_data;
    logic [ADDR_W-1:0] de_line_addr;
    logic              de_pop;
    logic [CNT_W-1:0]  q_count;

    modport master (
        input  redirect_valid, redirect_addr,
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_rsp_valid, ic_rsp_data,
        output de_lower_valid, de_upper_valid, de_lower_data, de_upper_data,
        output de_line_addr, q_count,
        input  de_pop
    );

    modport slave (
        output redirect_valid, redirect_addr,
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_rsp_valid, ic_rsp_data,
        input  de_lower_valid, de_upper_valid, de_lower_data, de_upper_data,
        input  de_line_addr, q_count,
        output de_pop
    );
endinterface

// File: rtl/ifetch_line_queue.sv
// Instruction-fetch line queue: a DEPTH-entry circular buffer of I-cache lines.
// It keeps one line-aligned cache read outstanding at a time, stores the returned
// lines in order and exposes the two oldest lines to decode as a lower/upper window.
// A redirect flushes the queue and restarts fetch; a response that is still in
// flight when the redirect happens is swallowed in DISCARD.
module ifetch_line_queue #(
    parameter int                LINE_W     = 128,
    parameter int                DEPTH      = 4,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input logic                 clk,
    input logic                 rst_n,
    ifetch_line_queue_if.master bus
);
    localparam int                LINE_B     = LINE_W / 8;
    localparam int                PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W      = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] LINE_INC   = ADDR_W'(LINE_B);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(LINE_B - 1));
    localparam logic [ADDR_W-1:0] RESET_LINE = RESET_ADDR & ALIGN_MASK;
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);

    typedef enum logic [1:0] {REQ, WAIT, FULL, DISCARD} state_t;

    state_t            state, state_next;
    logic [LINE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, upper_ptr;
    logic [CNT_W-1:0]  count, count_next;
    logic [ADDR_W-1:0] fetch_addr, head_addr, redirect_line;
    logic              req_valid, req_valid_next;
    logic              handshake, push, pop;

    // The cache accepts whenever our request is up and it is ready, even during a
    // redirect; that accepted request then owes us a response that must be dropped.
    assign redirect_line = bus.redirect_addr & ALIGN_MASK;
    assign handshake     = req_valid && bus.ic_req_ready;
    assign push          = (state == WAIT) && bus.ic_rsp_valid && !bus.redirect_valid;
    assign pop           = bus.de_pop && (count != '0) && !bus.redirect_valid;
    assign upper_ptr     = rd_ptr + PTR_W'(1);

    // Occupancy after this cycle's push/pop; a redirect empties the queue.
    always_comb begin
        count_next = count;
        if (bus.redirect_valid) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Fetch sequencing and the registered request-valid for the next cycle.
    always_comb begin
        state_next     = state;
        req_valid_next = 1'b0;
        if (bus.redirect_valid) begin
            unique case (state)
                WAIT:    state_next = bus.ic_rsp_valid ? REQ : DISCARD;
                REQ:     state_next = handshake ? DISCARD : REQ;
                DISCARD: state_next = DISCARD;
                default: state_next = REQ;
            endcase
        end else begin
            unique case (state)
                REQ:     if (handshake) state_next = WAIT;
                WAIT:    if (bus.ic_rsp_valid) state_next = (count_next < FULL_CNT) ? REQ : FULL;
                FULL:    if (count < FULL_CNT) state_next = REQ;
                DISCARD: if (bus.ic_rsp_valid) state_next = REQ;
                default: state_next = REQ;
            endcase
            // A request is raised one cycle after entering REQ and held until accepted.
            req_valid_next = (state == REQ) && (state_next == REQ) && (count_next < FULL_CNT);
        end
    end

    // Control state: FSM, pointers, occupancy and fetch/head addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= REQ;
            req_valid  <= 1'b0;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fetch_addr <= RESET_LINE;
            head_addr  <= RESET_LINE;
        end else begin
            state     <= state_next;
            req_valid <= req_valid_next;
            count     <= count_next;
            if (bus.redirect_valid) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fetch_addr <= redirect_line;
                head_addr  <= redirect_line;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr    <= rd_ptr + PTR_W'(1);
                    head_addr <= head_addr + LINE_INC;
                end
                if (handshake) begin
                    fetch_addr <= fetch_addr + LINE_INC;
                end
            end
        end
    end

    // Line storage; contents are only meaningful under the valid count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.ic_rsp_data;
        end
    end

    assign bus.ic_req_valid   = req_valid;
    assign bus.ic_req_addr    = fetch_addr;
    assign bus.de_lower_valid = (count != '0);
    assign bus.de_upper_valid = (count >= CNT_W'(2));
    assign bus.de_lower_data  = mem[rd_ptr];
    assign bus.de_upper_data  = mem[upper_ptr];
    assign bus.de_line_addr   = head_addr;
    assign bus.q_count        = count;
endmodule

// File: tb/tb_ifetch_line_queue.sv
// Directed bench for ifetch_line_queue with an in-order scoreboard of expected lines.
module tb_ifetch_line_queue;
    localparam int LINE_W = 128;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    ent_t exp_q[$];
    logic [ADDR_W-1:0] exp_head;

    ifetch_line_queue_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    ifetch_line_queue #(.LINE_W(LINE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_ADDR('0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1357_9BDF};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the whole decode window against the scoreboard.
    task automatic check_head(input string tag);
        chk({tag, ".count"}, LINE_W'(bus.q_count), LINE_W'(exp_q.size()));
        chk({tag, ".lower_valid"}, LINE_W'(bus.de_lower_valid), LINE_W'(exp_q.size() >= 1));
        chk({tag, ".upper_valid"}, LINE_W'(bus.de_upper_valid), LINE_W'(exp_q.size() >= 2));
        chk({tag, ".line_addr"}, LINE_W'(bus.de_line_addr), LINE_W'(exp_head));
        if (exp_q.size() >= 1) chk({tag, ".lower_data"}, bus.de_lower_data, exp_q[0].data);
        if (exp_q.size() >= 2) chk({tag, ".upper_data"}, bus.de_upper_data, exp_q[1].data);
    endtask

    // Wait (bounded) for a request and check its address; leaves the handshake edge next.
    task automatic wait_req(input string tag, input logic [ADDR_W-1:0] a);
        bus.ic_req_ready = 1'b1;
        for (int i = 0; i < 40 && !bus.ic_req_valid; i++) tick();
        chk({tag, ".req_valid"}, LINE_W'(bus.ic_req_valid), LINE_W'(1));
        chk({tag, ".req_addr"}, LINE_W'(bus.ic_req_addr), LINE_W'(a));
    endtask

    // Full request/response transaction with a 1-cycle cache.
    task automatic serve(input string tag, input logic [ADDR_W-1:0] a);
        wait_req(tag, a);
        tick();
        bus.ic_rsp_valid = 1'b1;
        bus.ic_rsp_data  = line_of(a);
        tick();
        bus.ic_rsp_valid = 1'b0;
        exp_q.push_back('{a, line_of(a)});
        check_head(tag);
    endtask

    task automatic do_pop(input string tag);
        bus.de_pop = 1'b1;
        tick();
        bus.de_pop = 1'b0;
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            exp_head = exp_head + ADDR_W'(LINE_W / 8);
        end
        check_head(tag);
    endtask

    task automatic do_redirect(input logic [ADDR_W-1:0] a);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = a;
        tick();
        bus.redirect_valid = 1'b0;
        exp_q.delete();
        exp_head = a & ~ADDR_W'(LINE_W / 8 - 1);
    endtask

    initial begin
        logic saw_req;
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.ic_req_ready   = 1'b1;
        bus.ic_rsp_valid   = 1'b0;
        bus.ic_rsp_data    = '0;
        bus.de_pop         = 1'b0;
        exp_head           = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state, then requests rise one cycle after release.
        chk("rst.req_valid", LINE_W'(bus.ic_req_valid), LINE_W'(0));
        chk("rst.req_addr", LINE_W'(bus.ic_req_addr), LINE_W'(0));
        check_head("rst");
        tick();
        chk("rst.req_valid_rise", LINE_W'(bus.ic_req_valid), LINE_W'(1));

        // Fill the queue with four lines, no fifth request.
        for (int i = 0; i < DEPTH; i++) serve("fill", ADDR_W'(i * 16));
        saw_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            saw_req = saw_req | bus.ic_req_valid;
        end
        chk("full.no_req", LINE_W'(saw_req), LINE_W'(0));
        check_head("full");

        // One pop from full, refill lands at the wrapped write pointer.
        do_pop("pop1");
        serve("wrap", 32'h40);
        bus.ic_req_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) do_pop("drain");

        // Redirect while waiting; the late response must be dropped.
        wait_req("pend", 32'h50);
        tick();
        do_redirect(32'h1234);
        check_head("redir_wait");
        chk("redir_wait.req_valid", LINE_W'(bus.ic_req_valid), LINE_W'(0));
        tick();
        bus.ic_rsp_valid = 1'b1;
        bus.ic_rsp_data  = line_of(32'h50);
        tick();
        bus.ic_rsp_valid = 1'b0;
        check_head("stale_drop");
        chk("stale_drop.req_valid", LINE_W'(bus.ic_req_valid), LINE_W'(0));
        serve("after_redir", 32'h1230);

        // Redirect together with a response: no DISCARD, request one cycle later.
        wait_req("pend2", 32'h1240);
        tick();
        bus.ic_rsp_valid = 1'b1;
        bus.ic_rsp_data  = line_of(32'h1240);
        do_redirect(32'h8000);
        bus.ic_rsp_valid = 1'b0;
        check_head("redir_rsp");
        chk("redir_rsp.req_valid", LINE_W'(bus.ic_req_valid), LINE_W'(0));
        chk("redir_rsp.req_addr", LINE_W'(bus.ic_req_addr), LINE_W'(32'h8000));
        tick();
        chk("redir_rsp.req_next", LINE_W'(bus.ic_req_valid), LINE_W'(1));
        serve("r8000", 32'h8000);
        serve("r8010", 32'h8010);

        // Push and pop in the same cycle at count 2.
        wait_req("pp", 32'h8020);
        tick();
        bus.ic_rsp_valid = 1'b1;
        bus.ic_rsp_data  = line_of(32'h8020);
        exp_q.push_back('{32'h8020, line_of(32'h8020)});
        do_pop("pushpop");
        bus.ic_rsp_valid = 1'b0;
        bus.ic_req_ready = 1'b0;
        do_pop("pp_drain1");
        do_pop("pp_drain2");
        do_pop("pop_empty");
        serve("after_empty", 32'h8030);

        // Fetch address wraps past the top of the address space.
        do_redirect(32'hFFFF_FFF5);
        serve("top", 32'hFFFF_FFF0);
        wait_req("wrap0", 32'h0);

        // Asynchronous reset mid-request drops the request at once.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.req_valid", LINE_W'(bus.ic_req_valid), LINE_W'(0));
        chk("async_rst.count", LINE_W'(bus.q_count), LINE_W'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        exp_head = '0;
        chk("rerst.req_valid", LINE_W'(bus.ic_req_valid), LINE_W'(0));
        chk("rerst.req_addr", LINE_W'(bus.ic_req_addr), LINE_W'(0));
        check_head("rerst");
        serve("rerst_line", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
